// File: rtl/tnn_pkg.sv
// tnn_pkg: shared weight codes, FSM states and accumulator sizing for the TNN neuron
package tnn_pkg;

    // 2'b10 is also a zero weight; it simply has no named code.
    typedef enum logic [1:0] {
        W_ZERO = 2'b00,
        W_POS  = 2'b01,
        W_NEG  = 2'b11
    } wcode_t;

    typedef enum logic [1:0] {
        ACC,
        CMP,
        DONE
    } state_t;

    // Smallest width that holds every feature at full scale plus the threshold.
    function automatic int acc_width(input int in_w, input int n, input int thresh);
        return $clog2(n * (2 ** in_w - 1) + thresh + 1);
    endfunction

endpackage

// File: rtl/tnn_lane_sum.sv
// tnn_lane_sum: splits one beat of features into its +1 and -1 partial sums
//   data     in   LANES*IN_W  features of this beat, lane j at [j*IN_W +: IN_W]
//   w        in   2*LANES     weight codes of this beat, lane j at [2j+1:2j]
//   beat_pos out  ACC_W       sum of lanes weighted +1
//   beat_neg out  ACC_W       sum of lanes weighted -1
module tnn_lane_sum
    import tnn_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int LANES = 2,
    parameter int ACC_W = 5
) (
    input  logic [LANES*IN_W-1:0] data,
    input  logic [2*LANES-1:0]    w,
    output logic [ACC_W-1:0]      beat_pos,
    output logic [ACC_W-1:0]      beat_neg
);

    always_comb begin
        beat_pos = '0;
        beat_neg = '0;
        for (int j = 0; j < LANES; j++) begin
            beat_pos += (w[2*j +: 2] == W_POS) ? ACC_W'(data[j*IN_W +: IN_W]) : '0;
            beat_neg += (w[2*j +: 2] == W_NEG) ? ACC_W'(data[j*IN_W +: IN_W]) : '0;
        end
    end

endmodule

// File: rtl/tnn_stream_neuron.sv
// tnn_stream_neuron: streaming ternary-weight neuron, cls = (pos > neg + THRESH)
//   clk, rst   clock, asynchronous active-high reset
//   w_i        2*NUM_FEAT weight codes, feature k at [2k+1:2k], static while busy
//   in_valid / in_ready / in_data / in_last   feature beat stream, LANES features per beat
//   out_valid / out_ready                     result handshake, result held until taken
//   cls_o      class bit
//   err_o      sticky beat-count mismatch flag, cleared only by rst
//   margin_o   signed pos - (neg + THRESH), present only with TNN_MARGIN_OUT_EN defined
module tnn_stream_neuron
    import tnn_pkg::*;
#(
    parameter int IN_W     = 2,
    parameter int NUM_FEAT = 8,
    parameter int LANES    = 2,
    parameter int THRESH   = 0,
    parameter int ACC_W    = acc_width(IN_W, NUM_FEAT, THRESH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*NUM_FEAT-1:0] w_i,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*IN_W-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  cls_o,
`ifdef TNN_MARGIN_OUT_EN
    output logic                  err_o,
    output logic signed [ACC_W:0] margin_o
`else
    output logic                  err_o
`endif
);

    localparam int            BEATS     = NUM_FEAT / LANES;
    localparam int            CW        = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [ACC_W:0] TH       = (ACC_W + 1)'(THRESH);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [ACC_W-1:0]   pos, neg, beat_pos, beat_neg;
    logic [2*LANES-1:0] w_beat;
    logic [ACC_W:0]     neg_th;
    logic               acc_fire, out_fire;

    // Weights follow the beat counter, so a wrapped counter reuses weights from feature 0.
    assign w_beat   = w_i[int'(cnt) * 2 * LANES +: 2 * LANES];
    assign acc_fire = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign neg_th   = {1'b0, neg} + TH;

    tnn_lane_sum #(.IN_W(IN_W), .LANES(LANES), .ACC_W(ACC_W)) u_lane_sum (
        .data     (in_data),
        .w        (w_beat),
        .beat_pos (beat_pos),
        .beat_neg (beat_neg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACC;
        else     state <= state_nxt;
    end

    // in_ready is gated by rst so nothing is accepted while reset is asserted.
    always_comb begin
        state_nxt = state == ACC  ? ((in_valid & in_last) ? CMP : ACC) :
                    state == CMP  ? DONE :
                    out_ready     ? ACC : DONE;
        in_ready  = (state == ACC) & ~rst;
        out_valid = state == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos   <= '0;
            neg   <= '0;
            cnt   <= '0;
            cls_o <= 1'b0;
            err_o <= 1'b0;
        end else begin
            if (acc_fire) begin
                pos   <= pos + beat_pos;
                neg   <= neg + beat_neg;
                cnt   <= cnt == LAST_BEAT ? '0 : cnt + 1'b1;
                err_o <= err_o | (in_last != (cnt == LAST_BEAT));
            end
            if (state == CMP) cls_o <= {1'b0, pos} > neg_th;
            if (out_fire) begin
                pos <= '0;
                neg <= '0;
                cnt <= '0;
            end
        end
    end

`ifdef TNN_MARGIN_OUT_EN
    // Both operands are below 2**ACC_W, so the difference fits ACC_W+1 signed bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               margin_o <= '0;
        else if (state == CMP) margin_o <= $signed({1'b0, pos}) - $signed(neg_th);
    end
`endif

endmodule

// File: tb/tb_tnn_stream_neuron.sv
// tb_tnn_stream_neuron: vector table, random model checks and handshake corner sequences
module tb_tnn_stream_neuron;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] w_i = '0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, cls_o, err_o;
    logic        in_ready1, out_valid1, cls1, err1;
`ifdef TNN_MARGIN_OUT_EN
    logic signed [5:0] margin0, margin1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tnn_stream_neuron u_dut (
        .clk(clk), .rst(rst), .w_i(w_i), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .cls_o(cls_o),
`ifdef TNN_MARGIN_OUT_EN
        .err_o(err_o), .margin_o(margin0)
`else
        .err_o(err_o)
`endif
    );

    tnn_stream_neuron #(.THRESH(1)) u_th1 (
        .clk(clk), .rst(rst), .w_i(w_i), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
        .cls_o(cls1),
`ifdef TNN_MARGIN_OUT_EN
        .err_o(err1), .margin_o(margin1)
`else
        .err_o(err1)
`endif
    );

    typedef struct {
        logic [15:0] w;
        logic [31:0] f;
        int          nb;
        logic        cls0;
        logic        cls1;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: feature k has value f[2k+:2] and weight code w[2*(k mod 8)+:2].
    function automatic int sum_sel(input logic [15:0] w, input logic [31:0] f, input int nb,
                                   input logic [1:0] code);
        int s = 0;
        for (int k = 0; k < nb * 2; k++)
            if (w[2*(k%8) +: 2] == code) s += int'(f[2*k +: 2]);
        return s;
    endfunction

    task automatic run(input logic [15:0] w, input logic [31:0] f, input int nb, input bit hold,
                       input string tag);
        int lat, p, n;
        p = sum_sel(w, f, nb, 2'b01);
        n = sum_sel(w, f, nb, 2'b11);
        @(negedge clk);
        w_i = w;
        for (int b = 0; b < nb; b++) begin
            int t = 0;
            in_valid = 1'b1;
            in_data  = f[b*4 +: 4];
            in_last  = (b == nb - 1);
            while (!in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd2);
        chk({tag, " cls"}, 32'(cls_o), 32'(p > n));
        chk({tag, " cls_th1"}, 32'(cls1), 32'(p > n + 1));
`ifdef TNN_MARGIN_OUT_EN
        chk({tag, " margin"}, 32'(int'(margin0)), 32'(p - n));
        chk({tag, " margin_th1"}, 32'(int'(margin1)), 32'(p - n - 1));
`endif
        if (!hold) begin
            @(negedge clk);
            chk({tag, " ready_after"}, 32'(in_ready), 32'd1);
            chk({tag, " valid_after"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit bad;
        tbl[0] = '{16'h5555, 32'h0000_FFFF, 4, 1'b1, 1'b1};
        tbl[1] = '{16'hFF55, 32'h0000_5555, 4, 1'b0, 1'b0};
        tbl[2] = '{16'hFF55, 32'h0000_5556, 4, 1'b1, 1'b0};
        tbl[3] = '{16'hAAAA, 32'h0000_FFFF, 4, 1'b0, 1'b0};
        tbl[4] = '{16'hFFFF, 32'h0000_FFFF, 4, 1'b0, 1'b0};
        tbl[5] = '{16'h0001, 32'h0000_0003, 4, 1'b1, 1'b1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst cls", 32'(cls_o), 32'd0);
        chk("rst err", 32'(err_o), 32'd0);
        rst = 1'b0;
        #1 chk("release in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            run(tbl[i].w, tbl[i].f, tbl[i].nb, 1'b0, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d const cls", i), 32'(cls_o), 32'(tbl[i].cls0));
            chk($sformatf("tbl%0d const cls_th1", i), 32'(cls1), 32'(tbl[i].cls1));
        end
        chk("no err", 32'(err_o), 32'd0);

        for (int i = 0; i < 20; i++)
            run(16'($urandom), 32'($urandom_range(0, 65535)), 4, 1'b0, $sformatf("rnd%0d", i));
        chk("rnd no err", 32'(err_o), 32'd0);

        // Backpressure: result held, input blocked
        out_ready = 1'b0;
        run(16'h5555, 32'h0000_00FF, 4, 1'b1, "bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp cls", 32'(cls_o), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp release ready", 32'(in_ready), 32'd1);
        run(16'hFFFF, 32'h0000_0055, 4, 1'b0, "bp2");
        chk("bp2 cleared cls", 32'(cls_o), 32'd0);

        // Async reset mid-inference
        @(negedge clk);
        w_i = 16'h5555;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            in_data  = 4'hF;
            in_last  = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1 chk("midrst in_ready", 32'(in_ready), 32'd0);
        #1 rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bad |= out_valid;
        end
        chk("midrst no out_valid", 32'(bad), 32'd0);
        run(16'hFF55, 32'h0000_5500, 4, 1'b0, "postrst");
        chk("postrst cls", 32'(cls_o), 32'd0);

        // Beat-count mismatch, sticky error
        run(16'h5555, 32'h0000_00FF, 2, 1'b0, "short");
        chk("short cls", 32'(cls_o), 32'd1);
        chk("short err", 32'(err_o), 32'd1);
        run(16'hFF55, 32'h0000_5555, 4, 1'b0, "after_short");
        chk("err sticky", 32'(err_o), 32'd1);
        run(16'h5555, 32'h000F_0000, 5, 1'b0, "wrap");
        chk("wrap cls", 32'(cls_o), 32'd1);
        chk("wrap err", 32'(err_o), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("err cleared", 32'(err_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
